// File: rtl/core_pkg.sv
// Shared definitions for the PC sequencer slice.
//   pc_state_e           : sequencer state encoding (RUN, TRAP, HALT)
//   DEFAULT_RESET_VECTOR : PC loaded on reset
//   DEFAULT_TRAP_VECTOR  : PC loaded after a misaligned control-flow target
//   PC_INC               : sequential PC increment
package core_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    TRAP = 2'd1,
    HALT = 2'd2
  } pc_state_e;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0100;
  localparam int          PC_INC               = 4;

endpackage

// File: rtl/pc_sequencer_if.sv
// Control/target bundle between the core datapath and the PC sequencer.
//   master : core side, drives stall/halt/branch/jump requests and targets
//   slave  : sequencer side, drives PC, trap, halt and retire-count outputs
interface pc_sequencer_if #(
  parameter int XLEN = 32
);
  logic            stall_PC;
  logic            branch_taken_PC;
  logic [XLEN-1:0] in_Branch_Target_PC;
  logic            jump_reg_PC;
  logic [XLEN-1:0] in_Jalr_Target_PC;
  logic            halt_PC;
  logic [XLEN-1:0] out_PC;
  logic [XLEN-1:0] out_PC_Plus4;
  logic            out_Misalign_Trap;
  logic [XLEN-1:0] out_Trap_EPC;
  logic            out_Halted;
  logic [XLEN-1:0] out_Retire_Count;

  modport master (
    output stall_PC, branch_taken_PC, in_Branch_Target_PC,
           jump_reg_PC, in_Jalr_Target_PC, halt_PC,
    input  out_PC, out_PC_Plus4, out_Misalign_Trap,
           out_Trap_EPC, out_Halted, out_Retire_Count
  );

  modport slave (
    input  stall_PC, branch_taken_PC, in_Branch_Target_PC,
           jump_reg_PC, in_Jalr_Target_PC, halt_PC,
    output out_PC, out_PC_Plus4, out_Misalign_Trap,
           out_Trap_EPC, out_Halted, out_Retire_Count
  );
endinterface

// File: rtl/pc_next_sel.sv
// Combinational next-PC priority mux with alignment check.
//   pc            : current PC
//   branch_taken  / branch_target : conditional branch request and target
//   jump_reg      / jalr_target   : JALR request and raw rs1+imm target
//   target        : selected next PC (JALR > branch > PC+4)
//   misaligned    : target is not word aligned
module pc_next_sel
  import core_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            jump_reg,
  input  logic [XLEN-1:0] jalr_target,
  output logic [XLEN-1:0] target,
  output logic            misaligned
);

  always_comb begin
    target = pc + XLEN'(PC_INC);
    if (jump_reg) begin
      target = {jalr_target[XLEN-1:1], 1'b0};
    end else if (branch_taken) begin
      target = branch_target;
    end
  end

  assign misaligned = |target[1:0];

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter owner: registers the next PC, traps misaligned targets,
// handles stall/halt and counts retired instructions.
//   clk : core clock, rising edge
//   rst : synchronous active-high reset
//   bus : pc_sequencer_if slave (requests/targets in, PC/status out)
//
// state | meaning
// RUN   | normal sequencing, PC advances on every unstalled cycle
// TRAP  | one-cycle trap pulse, PC is redirected to TRAP_VECTOR next
// HALT  | core stopped, everything frozen until reset
module pc_sequencer
  import core_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR),
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(DEFAULT_TRAP_VECTOR)
) (
  input logic          clk,
  input logic          rst,
  pc_sequencer_if.slave bus
);

  pc_state_e       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic [XLEN-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] target;
  logic            misaligned;

  pc_next_sel #(.XLEN(XLEN)) u_next_sel (
    .pc            (pc_q),
    .branch_taken  (bus.branch_taken_PC),
    .branch_target (bus.in_Branch_Target_PC),
    .jump_reg      (bus.jump_reg_PC),
    .jalr_target   (bus.in_Jalr_Target_PC),
    .target        (target),
    .misaligned    (misaligned)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= RESET_VECTOR;
      epc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    epc_d   = epc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RUN: begin
        if (!bus.stall_PC) begin
          if (bus.halt_PC) begin
            state_d = HALT;
          end else if (misaligned) begin
            // faulting instruction does not retire; PC stays on it
            state_d = TRAP;
            epc_d   = pc_q;
          end else begin
            pc_d  = target;
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      TRAP: begin
        pc_d    = TRAP_VECTOR;
        state_d = RUN;
      end
      HALT: ;
      default: state_d = RUN;
    endcase
  end

  assign bus.out_PC            = pc_q;
  assign bus.out_PC_Plus4      = pc_q + XLEN'(PC_INC);
  assign bus.out_Misalign_Trap = (state_q == TRAP);
  assign bus.out_Trap_EPC      = epc_q;
  assign bus.out_Halted        = (state_q == HALT);
  assign bus.out_Retire_Count  = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus random
// traffic, checked every cycle against a behavioural model.
module tb_pc_sequencer;

  logic clk = 1'b0;
  logic rst;
  logic rst_s;
  always #5 clk = ~clk;

  pc_sequencer_if #(.XLEN(32)) bus ();
  pc_sequencer_if #(.XLEN(4))  sbus ();

  pc_sequencer #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // narrow instance so that counter and PC wrap are reachable quickly
  pc_sequencer #(.XLEN(4), .RESET_VECTOR(4'h0), .TRAP_VECTOR(4'h8)) dut_s (
    .clk (clk),
    .rst (rst_s),
    .bus (sbus)
  );

  int total = 0;
  int bad   = 0;

  // behavioural model
  logic [31:0] m_pc, m_epc, m_cnt;
  bit          m_trap, m_halted;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic model_step();
    logic [31:0] t;
    if (rst) begin
      m_pc = 32'h0; m_epc = 0; m_cnt = 0; m_trap = 0; m_halted = 0;
    end else if (m_halted) begin
      // frozen
    end else if (m_trap) begin
      m_pc   = 32'h100;
      m_trap = 0;
    end else if (bus.stall_PC) begin
      // hold
    end else if (bus.halt_PC) begin
      m_halted = 1;
    end else begin
      if (bus.jump_reg_PC)          t = bus.in_Jalr_Target_PC - (bus.in_Jalr_Target_PC % 2);
      else if (bus.branch_taken_PC) t = bus.in_Branch_Target_PC;
      else                          t = m_pc + 4;
      if (t % 4 != 0) begin
        m_trap = 1;
        m_epc  = m_pc;
      end else begin
        m_pc  = t;
        m_cnt = m_cnt + 1;
      end
    end
  endtask

  task automatic compare_all();
    chk("pc",     bus.out_PC,                  m_pc);
    chk("plus4",  bus.out_PC_Plus4,            m_pc + 32'd4);
    chk("trap",   {31'd0, bus.out_Misalign_Trap}, {31'd0, m_trap});
    chk("epc",    bus.out_Trap_EPC,            m_epc);
    chk("halted", {31'd0, bus.out_Halted},     {31'd0, m_halted});
    chk("count",  bus.out_Retire_Count,        m_cnt);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle();
    bus.stall_PC = 0; bus.halt_PC = 0;
    bus.branch_taken_PC = 0; bus.jump_reg_PC = 0;
    bus.in_Branch_Target_PC = 0; bus.in_Jalr_Target_PC = 0;
  endtask

  task automatic branch_to(input logic [31:0] a);
    idle();
    bus.branch_taken_PC = 1; bus.in_Branch_Target_PC = a;
    tick();
    idle();
  endtask

  logic [31:0] saved_pc, saved_cnt;

  initial begin
    sbus.stall_PC = 0; sbus.halt_PC = 0;
    sbus.branch_taken_PC = 0; sbus.jump_reg_PC = 0;
    sbus.in_Branch_Target_PC = 0; sbus.in_Jalr_Target_PC = 0;
    rst_s = 1;
    idle();
    m_pc = 0; m_epc = 0; m_cnt = 0; m_trap = 0; m_halted = 0;
    @(negedge clk);

    // reset and free run
    rst = 1; tick(); rst = 0;
    chk("rst_pc", bus.out_PC, 32'd0);
    chk("rst_cnt", bus.out_Retire_Count, 32'd0);
    repeat (3) tick();
    chk("free_pc", bus.out_PC, 32'd12);
    chk("free_cnt", bus.out_Retire_Count, 32'd3);
    chk("free_plus4", bus.out_PC_Plus4, 32'd16);

    // branch and JALR priority
    branch_to(32'd100);
    branch_to(32'd96);
    chk("br_pc", bus.out_PC, 32'd96);
    chk("br_cnt", bus.out_Retire_Count, 32'd5);
    bus.branch_taken_PC = 1; bus.in_Branch_Target_PC = 32'd96;
    bus.jump_reg_PC = 1; bus.in_Jalr_Target_PC = 32'd201;
    tick(); idle();
    chk("jalr_pc", bus.out_PC, 32'd200);

    // misaligned branch -> trap
    branch_to(32'd8);
    saved_cnt = bus.out_Retire_Count;
    branch_to(32'h0000_000A);
    chk("trap_pc", bus.out_PC, 32'd8);
    chk("trap_pulse", {31'd0, bus.out_Misalign_Trap}, 32'd1);
    chk("trap_epc", bus.out_Trap_EPC, 32'd8);
    tick();
    chk("trap_vec", bus.out_PC, 32'h100);
    chk("trap_cnt", bus.out_Retire_Count, saved_cnt);
    chk("trap_clr", {31'd0, bus.out_Misalign_Trap}, 32'd0);

    // stall masks halt and branch, then halt freezes
    saved_pc = bus.out_PC; saved_cnt = bus.out_Retire_Count;
    bus.stall_PC = 1; bus.branch_taken_PC = 1; bus.halt_PC = 1;
    bus.in_Branch_Target_PC = 32'h40;
    repeat (3) tick();
    chk("stall_pc", bus.out_PC, saved_pc);
    chk("stall_cnt", bus.out_Retire_Count, saved_cnt);
    bus.stall_PC = 0;
    tick();
    chk("halt_flag", {31'd0, bus.out_Halted}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      bus.stall_PC = 1'($urandom); bus.halt_PC = 1'($urandom);
      bus.branch_taken_PC = 1'($urandom); bus.jump_reg_PC = 1'($urandom);
      bus.in_Branch_Target_PC = $urandom; bus.in_Jalr_Target_PC = $urandom;
      tick();
    end
    chk("halt_pc", bus.out_PC, saved_pc);
    chk("halt_cnt", bus.out_Retire_Count, saved_cnt);

    // reset out of HALT
    idle(); rst = 1; tick(); rst = 0;
    chk("rst_halt_pc", bus.out_PC, 32'd0);
    chk("rst_halt_h", {31'd0, bus.out_Halted}, 32'd0);
    chk("rst_halt_cnt", bus.out_Retire_Count, 32'd0);

    // reset while in TRAP (misaligned JALR: 7 -> 6)
    bus.jump_reg_PC = 1; bus.in_Jalr_Target_PC = 32'd7;
    tick(); idle();
    chk("jalr_trap", {31'd0, bus.out_Misalign_Trap}, 32'd1);
    rst = 1; tick(); rst = 0;
    chk("rst_trap_pc", bus.out_PC, 32'd0);
    chk("rst_trap_t", {31'd0, bus.out_Misalign_Trap}, 32'd0);
    chk("rst_trap_epc", bus.out_Trap_EPC, 32'd0);
    chk("rst_trap_cnt", bus.out_Retire_Count, 32'd0);

    // PC wrap
    branch_to(32'hFFFF_FFFC);
    chk("wrap_plus4", bus.out_PC_Plus4, 32'd0);
    tick();
    chk("wrap_pc", bus.out_PC, 32'd0);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(49) == 0);
      bus.stall_PC = ($urandom_range(3) == 0);
      bus.halt_PC = ($urandom_range(39) == 0);
      bus.branch_taken_PC = ($urandom_range(2) == 0);
      bus.jump_reg_PC = ($urandom_range(3) == 0);
      bus.in_Branch_Target_PC = $urandom;
      bus.in_Jalr_Target_PC = $urandom;
      if ($urandom_range(7) != 0) bus.in_Branch_Target_PC[1:0] = 2'b00;
      if ($urandom_range(7) != 0) bus.in_Jalr_Target_PC[1] = 1'b0;
      tick();
    end
    rst = 0; idle();

    // narrow instance: counter and PC wrap
    rst_s = 1; tick(); rst_s = 0;
    repeat (15) tick();
    chk("s_cnt15", {28'd0, sbus.out_Retire_Count}, 32'd15);
    chk("s_pc15", {28'd0, sbus.out_PC}, 32'd12);
    tick();
    chk("s_cnt_wrap", {28'd0, sbus.out_Retire_Count}, 32'd0);
    chk("s_pc_wrap", {28'd0, sbus.out_PC}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
